rom_burst_reader: RTL and testbench

Sequencing controller that streams a contiguous run of words out of a synchronous, enable-gated ROM (one-cycle read latency, output forced to zero when not enabled) to a downstream consumer. A single start command loads base address and word count; the block then issues back-to-back ROM reads under valid/ready flow control, absorbing backpressure in a 2-entry skid buffer. It sits between the coefficient/support-vector ROMs and the compute datapaths that consume them.

---
 rtl/rom_burst_reader_pkg.sv | 27 ++
 rtl/rom_skid_buffer.sv | 56 +++++
 rtl/rom_burst_reader.sv | 136 +++++++++++++
 tb/tb_rom_burst_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_burst_reader_pkg.sv
// Shared definitions for the ROM burst reader: width helper, default sizes
// and the controller state encoding.
package rom_burst_reader_pkg;

    // Ceiling log2, used to size the ROM address from the ROM depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    localparam int unsigned DEF_BLOCK_LENGTH = 12;
    localparam int unsigned DEF_MEM_DEPTH    = 250;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/rom_skid_buffer.sv
// Two-entry FIFO that absorbs ROM words while the consumer stalls.
// Head word is presented combinationally from storage.
module rom_skid_buffer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       occupancy_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against occupancy and compute pointer/count updates.
    always_comb begin
        do_pop   = pop_i && (occ_q != 2'd0);
        do_push  = push_i && ((occ_q != 2'd2) || do_pop);
        rd_ptr_d = rd_ptr_q ^ do_pop;
        wr_ptr_d = wr_ptr_q ^ do_push;
        occ_d    = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Storage and pointers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign data_o      = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign empty_o     = (occ_q == 2'd0);
    assign full_o      = (occ_q == 2'd2);

endmodule

// File: rtl/rom_burst_reader.sv
// Streams a contiguous, wrapping run of words out of a one-cycle-latency
// enable-gated ROM to a valid/ready consumer, buffering in a 2-entry skid FIFO.
module rom_burst_reader
    import rom_burst_reader_pkg::*;
#(
    parameter int unsigned BLOCK_LENGTH = DEF_BLOCK_LENGTH,
    parameter int unsigned MEM_DEPTH    = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_WIDTH   = clog2(MEM_DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_address,
    input  logic [ADDR_WIDTH:0]     count,
    output logic                    busy,
    output logic                    done,
    output logic                    rom_enable,
    output logic [ADDR_WIDTH-1:0]   rom_address,
    input  logic [BLOCK_LENGTH-1:0] rom_data,
    output logic [BLOCK_LENGTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     issue_left_q, issue_left_d;
    logic [ADDR_WIDTH:0]     deliver_left_q, deliver_left_d;
    logic                    inflight_q, inflight_d;
    logic                    done_q, done_d;

    logic                    issue;
    logic                    pop;
    logic [1:0]              occ;
    logic                    buf_empty;
    logic                    buf_full;

    rom_skid_buffer #(
        .WIDTH (BLOCK_LENGTH)
    ) u_skid (
        .clock_i     (clock),
        .reset_i     (reset),
        .push_i      (inflight_q),
        .data_i      (rom_data),
        .pop_i       (pop),
        .data_o      (out_data),
        .occupancy_o (occ),
        .empty_o     (buf_empty),
        .full_o      (buf_full)
    );

    // State register and all controller counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            inflight_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            inflight_q     <= inflight_d;
            done_q         <= done_d;
        end
    end

    // Next-state: command acceptance, read issue bookkeeping and delivery count.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        inflight_d     = issue;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle itself still reads as idle, so a start there is dropped.
                if (start && !done_q) begin
                    addr_d         = base_address;
                    issue_left_d   = count;
                    deliver_left_d = count;
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d       = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                    if (issue_left_q == CNT_ONE) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && pop) begin
            deliver_left_d = deliver_left_q - 1'b1;
            if (deliver_left_q == CNT_ONE) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // Outputs: reads are issued only while buffered plus in-flight words stay within two.
    always_comb begin
        out_valid   = !buf_empty;
        pop         = out_valid && out_ready;
        issue       = (state_q == RUN) && (issue_left_q != '0) && !buf_full &&
                      (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        rom_enable  = issue;
        rom_address = issue ? addr_q : '0;
        busy        = (state_q != IDLE);
        done        = done_q;
        out_last    = out_valid && (deliver_left_q == CNT_ONE);
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a counting-init ROM model.
module tb_rom_burst_reader;

    localparam int BL    = 12;
    localparam int DEPTH = 250;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic [AW:0]   count;
    logic          busy, done, rom_enable, out_valid, out_ready, out_last;
    logic [AW-1:0] rom_address;
    logic [BL-1:0] rom_data;
    logic [BL-1:0] out_data;

    rom_burst_reader #(
        .BLOCK_LENGTH (BL),
        .MEM_DEPTH    (DEPTH),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .base_address (base_address),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .rom_enable   (rom_enable),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // ROM: word i = i, last word all ones; zero when not enabled.
    logic [BL-1:0] rom_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = BL'(i);
        rom_mem[DEPTH-1] = '1;
    end
    always @(posedge clk) rom_data <= rom_enable ? rom_mem[rom_address] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation record, sampled mid-cycle.
    int hs_data[$];
    int hs_last[$];
    int hs_cyc[$];
    int en_addr[$];
    int en_total = 0, valid_total = 0, done_total = 0, done_cyc = -1;
    int done_busy = 0, outs = 0, over_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            outs = 0;
        end else begin
            if (rom_enable) begin
                en_total++;
                outs++;
                en_addr.push_back(int'(rom_address));
            end
            if (out_valid) valid_total++;
            if (out_valid && out_ready) begin
                hs_data.push_back(int'(out_data));
                hs_last.push_back(int'(out_last));
                hs_cyc.push_back(cyc);
                outs--;
            end
            if (outs > 2) over_cnt++;
            if (done) begin
                done_total++;
                done_cyc = cyc;
                if (busy) done_busy++;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] rpat = 4'b1001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got_q[$], input int h0, input int exp_q[$]);
        check({tag, "_count"}, got_q.size() - h0, exp_q.size());
        for (int k = 0; k < exp_q.size() && (h0 + k) < got_q.size(); k++)
            check($sformatf("%s_%0d", tag, k), got_q[h0 + k], exp_q[k]);
    endtask

    task automatic check_last(input string tag, input int h0, input int n);
        for (int k = 0; k < n && (h0 + k) < hs_last.size(); k++)
            check($sformatf("%s_last%0d", tag, k), hs_last[h0 + k], (k == n - 1) ? 1 : 0);
    endtask

    task automatic run_cmd(input int b, input int n, input bit pat, input int mid_at, output int e0);
        int d0;
        d0 = done_total;
        base_address = AW'(b);
        count = (AW + 1)'(n);
        start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_total != d0) break;
            out_ready = pat ? rpat[i % 4] : 1'b1;
            if (i == mid_at) begin
                start = 1'b1;
                base_address = AW'(100);
                count = (AW + 1)'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", done_total - d0, 1);
    endtask

    int e0, h0, a0, en0, v0, d0;
    int exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_address = '0; count = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", rom_enable, 0);
        check("rst_addr", rom_address, 0);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic burst
        h0 = hs_data.size(); a0 = en_addr.size(); en0 = en_total; v0 = valid_total;
        run_cmd(10, 5, 1'b0, -1, e0);
        exp_q = '{10, 11, 12, 13, 14};
        check_seq("t1_data", hs_data, h0, exp_q);
        check_seq("t1_addr", en_addr, a0, exp_q);
        check_last("t1", h0, 5);
        check("t1_first_cyc", hs_cyc[h0], e0 + 2);
        check("t1_last_cyc", hs_cyc[h0 + 4], e0 + 6);
        check("t1_done_cyc", done_cyc, e0 + 7);
        check("t1_en_cnt", en_total - en0, 5);
        check("t1_valid_cnt", valid_total - v0, 5);
        check("t1_done_busy", done_busy, 0);

        // Address wrap
        repeat (2) @(posedge clk);
        #1;
        h0 = hs_data.size(); a0 = en_addr.size();
        run_cmd(247, 5, 1'b0, -1, e0);
        exp_q = '{247, 248, 'hFFF, 0, 1};
        check_seq("t2_data", hs_data, h0, exp_q);
        exp_q = '{247, 248, 249, 0, 1};
        check_seq("t2_addr", en_addr, a0, exp_q);
        check_last("t2", h0, 5);

        // Zero-length command
        repeat (2) @(posedge clk);
        #1;
        h0 = hs_data.size(); en0 = en_total; v0 = valid_total;
        run_cmd(5, 0, 1'b0, -1, e0);
        check("t3_done_cyc", done_cyc, e0);
        check("t3_en_cnt", en_total - en0, 0);
        check("t3_valid_cnt", valid_total - v0, 0);
        check("t3_busy", busy, 0);

        // Backpressure pattern 1,0,0,1
        repeat (2) @(posedge clk);
        #1;
        h0 = hs_data.size(); en0 = en_total; d0 = over_cnt;
        run_cmd(0, 8, 1'b1, -1, e0);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_seq("t4_data", hs_data, h0, exp_q);
        check_last("t4", h0, 8);
        check("t4_en_cnt", en_total - en0, 8);
        check("t4_overfill", over_cnt - d0, 0);

        // Start while busy ignored
        repeat (2) @(posedge clk);
        #1;
        h0 = hs_data.size(); en0 = en_total;
        run_cmd(10, 5, 1'b0, 2, e0);
        exp_q = '{10, 11, 12, 13, 14};
        check_seq("t5_data", hs_data, h0, exp_q);
        check("t5_en_cnt", en_total - en0, 5);

        // Start in the done cycle ignored
        repeat (2) @(posedge clk);
        #1;
        h0 = hs_data.size(); en0 = en_total;
        base_address = AW'(30); count = (AW + 1)'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        check("t5b_done_wait", done, 1);
        base_address = AW'(50); count = (AW + 1)'(1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5b_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t5b_en_cnt", en_total - en0, 2);
        check("t5b_hs_cnt", hs_data.size() - h0, 2);

        // Start after done accepted normally
        h0 = hs_data.size();
        run_cmd(20, 2, 1'b0, -1, e0);
        exp_q = '{20, 21};
        check_seq("t5c_data", hs_data, h0, exp_q);

        // Reset mid-stream
        repeat (2) @(posedge clk);
        #1;
        base_address = AW'(0); count = (AW + 1)'(20); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_en", rom_enable, 0);
        check("t6_addr", rom_address, 0);
        check("t6_data", out_data, 0);
        check("t6_valid", out_valid, 0);
        check("t6_last", out_last, 0);
        reset = 1'b0;
        d0 = done_total; en0 = en_total;
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_done", done_total - d0, 0);
        check("t6_no_reads", en_total - en0, 0);
        h0 = hs_data.size();
        run_cmd(3, 2, 1'b0, -1, e0);
        exp_q = '{3, 4};
        check_seq("t6_data_after", hs_data, h0, exp_q);
        check_last("t6", h0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
